// File: rtl/mem_lsu_if.sv
// Data-memory request/response bundle between the MEM-stage LSU (master) and data memory (slave).
interface mem_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [3:0]        dm_be;
    logic [31:0]       dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [31:0]       dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata
    );
    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues data-memory accesses from EX/MEM controls and formats
// load results for MEM/WB. Optional misalignment trap enabled by LSU_MISALIGN_CHECK_EN.
module mem_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_wreg_data,
    input  logic [2:0]  mem_func3,
    input  logic        mem_memrd,
    input  logic        mem_memwr,
    input  logic        mem_mem2reg,
    input  logic        stall_me,
    mem_lsu_if.master   dm,
    output logic        stallreq_mem,
    output logic [31:0] wb_wdata,
    output logic        misalign
);
    generate
        if (DATA_W != 32 || ADDR_W < 2 || ADDR_W > 32) begin : g_bad_param
            $error("mem_lsu: DATA_W must be 32 and ADDR_W must be 2..32");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t            r_state;
    logic [31:0]       r_ld_q;
    logic [ADDR_W-1:0] w_a;
    logic              w_access, w_store, w_byte, w_half, w_mis;
    logic [3:0]        w_be;
    logic [31:0]       w_st_data, w_ld_data;
    logic [7:0]        w_rbyte;
    logic [15:0]       w_rhalf;

    assign w_a      = mem_wdata[ADDR_W-1:0];
    assign w_access = mem_memrd | mem_memwr;
    assign w_store  = mem_memwr;  // rd+wr together is illegal; it resolves as a store
    assign w_byte   = (mem_func3[1:0] == 2'b00);
    assign w_half   = (mem_func3[1:0] == 2'b01);

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_mis = w_access & ((w_half & w_a[0]) | (~w_byte & ~w_half & (w_a[1:0] != 2'b00)));
`else
    assign w_mis = 1'b0;
`endif
    assign misalign = w_mis;

    always_comb begin
        w_be      = 4'b1111;
        w_st_data = mem_wreg_data;
        if (w_byte) begin
            w_be      = 4'b0001 << w_a[1:0];
            w_st_data = {4{mem_wreg_data[7:0]}};
        end else if (w_half) begin
            w_be      = w_a[1] ? 4'b1100 : 4'b0011;
            w_st_data = {2{mem_wreg_data[15:0]}};
        end
    end

    always_comb begin
        w_rbyte = dm.dm_rdata[7:0];
        case (w_a[1:0])
            2'd1:    w_rbyte = dm.dm_rdata[15:8];
            2'd2:    w_rbyte = dm.dm_rdata[23:16];
            2'd3:    w_rbyte = dm.dm_rdata[31:24];
            default: w_rbyte = dm.dm_rdata[7:0];
        endcase
        w_rhalf = w_a[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
        // func3[2] marks the unsigned variants (BU/HU)
        if (w_byte)      w_ld_data = {{24{~mem_func3[2] & w_rbyte[7]}}, w_rbyte};
        else if (w_half) w_ld_data = {{16{~mem_func3[2] & w_rhalf[15]}}, w_rhalf};
        else             w_ld_data = dm.dm_rdata;
    end

    assign dm.dm_req    = ((r_state == IDLE) & w_access & ~w_mis) | (r_state == REQ);
    assign dm.dm_we     = w_store;
    assign dm.dm_addr   = {w_a[ADDR_W-1:2], 2'b00};
    assign dm.dm_be     = w_store ? w_be : 4'b0000;
    assign dm.dm_wdata  = w_st_data;
    assign stallreq_mem = w_access & (r_state != DONE);
    assign wb_wdata     = mem_mem2reg ? r_ld_q : mem_wdata;

    // DONE holds until the pipeline moves, so a held instruction is never reissued
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ld_q  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_access) begin
                    if (w_mis) begin
                        r_state <= DONE;
                        r_ld_q  <= '0;
                    end else if (dm.dm_gnt) begin
                        r_state <= w_store ? DONE : WAIT_R;
                    end else begin
                        r_state <= REQ;
                    end
                end
                REQ:    if (dm.dm_gnt) r_state <= w_store ? DONE : WAIT_R;
                WAIT_R: if (dm.dm_rvalid) begin
                    r_ld_q  <= w_ld_data;
                    r_state <= DONE;
                end
                DONE:   if (!stall_me) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu against a transaction-level reference model, plus directed literal checks.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_wdata, mem_wreg_data;
  logic [2:0]  mem_func3;
  logic        mem_memrd, mem_memwr, mem_mem2reg, stall_me;
  logic        stallreq_mem, misalign;
  logic [31:0] wb_wdata;

  always #5 clk = ~clk;

  mem_lsu_if #(.ADDR_W(32)) dm_if();

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .mem_wdata(mem_wdata), .mem_wreg_data(mem_wreg_data),
    .mem_func3(mem_func3), .mem_memrd(mem_memrd), .mem_memwr(mem_memwr),
    .mem_mem2reg(mem_mem2reg), .stall_me(stall_me), .dm(dm_if),
    .stallreq_mem(stallreq_mem), .wb_wdata(wb_wdata), .misalign(misalign)
  );

  int total = 0, bad = 0;
  bit chk_en = 0;

  // literal expectations posted by the stimulus, checked by the compare process
  string       lit_name [512];
  logic [31:0] lit_act  [512];
  logic [31:0] lit_exp  [512];
  int          lit_seq = 0, lit_seen = 0;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    return (n == 4) ? 0 : (int'(a[1:0]) / n) * n;
  endfunction

  function automatic logic mis_of(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    int n = nbytes(f3);
    return (n == 2) ? a[0] : (n == 4) ? (a[1:0] != 2'b00) : 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    int o = lane_off(f3, a);
    logic [3:0] b = 4'b0;
    for (int i = 0; i < 4; i++) if (i >= o && i < o + n) b[i] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] wd_of(input logic [2:0] f3, input logic [31:0] d);
    int n = nbytes(f3);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ld_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int n = nbytes(f3);
    int o = lane_off(f3, a);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1);
    logic [31:0] v = (rd >> (8*o)) & mask;
    if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  logic        m_granted, m_done;
  logic [31:0] m_ldq;

  always @(posedge clk) begin
    if (rst) begin
      m_granted <= 1'b0;
      m_done    <= 1'b0;
      m_ldq     <= 32'h0;
    end else if ((mem_memrd | mem_memwr) && !m_done) begin
      if (mis_of(mem_func3, mem_wdata)) begin
        m_done <= 1'b1;
        m_ldq  <= 32'h0;
      end else if (!m_granted) begin
        if (dm_if.dm_gnt) begin
          m_granted <= 1'b1;
          if (mem_memwr) m_done <= 1'b1;
        end
      end else if (dm_if.dm_rvalid) begin
        m_done <= 1'b1;
        m_ldq  <= ld_of(mem_func3, mem_wdata, dm_if.dm_rdata);
      end
    end else if (m_done && !stall_me) begin
      m_done    <= 1'b0;
      m_granted <= 1'b0;
    end
  end

  // ---------------- compare process ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic acc, st, mis, ereq;
    #2;
    if (chk_en) begin
      acc  = mem_memrd | mem_memwr;
      st   = mem_memwr;
      mis  = acc && mis_of(mem_func3, mem_wdata);
      ereq = acc && !m_granted && !m_done && !mis;
      chk("dm_req", {31'b0, dm_if.dm_req}, {31'b0, ereq});
      chk("stallreq_mem", {31'b0, stallreq_mem}, {31'b0, acc && !m_done});
      chk("misalign", {31'b0, misalign}, {31'b0, mis});
      chk("wb_wdata", wb_wdata, mem_mem2reg ? m_ldq : mem_wdata);
      if (ereq) begin
        chk("dm_we", {31'b0, dm_if.dm_we}, {31'b0, st});
        chk("dm_addr", dm_if.dm_addr, {mem_wdata[31:2], 2'b00});
        chk("dm_be", {28'b0, dm_if.dm_be}, {28'b0, st ? be_of(mem_func3, mem_wdata) : 4'b0000});
        if (st) chk("dm_wdata", dm_if.dm_wdata, wd_of(mem_func3, mem_wreg_data));
      end
    end
    while (lit_seen < lit_seq) begin
      chk(lit_name[lit_seen], lit_act[lit_seen], lit_exp[lit_seen]);
      lit_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (lit_seq < 512) begin
      lit_name[lit_seq] = nm;
      lit_act[lit_seq]  = act;
      lit_exp[lit_seq]  = exp;
      lit_seq++;
    end
  endtask

  int          op_stalls, op_reqs, op_hs, op_cycles;
  logic [31:0] op_addr, op_wd, op_wb;
  logic [3:0]  op_be;
  logic        op_mis;

  task automatic do_op(input logic rd, input logic wr, input logic m2r, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input int gdly, input int rdly, input int sdly,
                       input logic [31:0] rdat, input bit fixed);
    int  w = 0, s = 0;
    bit  fin = 0, first = 1;
    op_stalls = 0; op_reqs = 0; op_hs = 0; op_cycles = 0;
    op_addr = 0; op_wd = 0; op_wb = 0; op_be = 0; op_mis = 0;
    while (!fin && op_cycles < 80) begin
      @(negedge clk);
      mem_memrd = rd; mem_memwr = wr; mem_mem2reg = m2r; mem_func3 = f3;
      mem_wdata = addr; mem_wreg_data = data;
      dm_if.dm_rdata  = fixed ? rdat : $urandom();
      dm_if.dm_gnt    = !m_granted && !m_done && (op_cycles >= gdly);
      dm_if.dm_rvalid = (m_granted && !m_done && (w + 1 >= rdly)) ||
                        (m_done && ($urandom_range(3) == 0)) ||
                        (!m_granted && !dm_if.dm_gnt && ($urandom_range(3) == 0));
      stall_me = m_done && (s < sdly);
      #3;
      if (op_cycles == 0) op_mis = misalign;
      if (stallreq_mem) op_stalls++;
      if (dm_if.dm_req) begin
        op_reqs++;
        if (dm_if.dm_gnt) op_hs++;
        if (first) begin
          op_addr = dm_if.dm_addr; op_be = dm_if.dm_be; op_wd = dm_if.dm_wdata;
          first = 0;
        end
      end
      if (!(rd | wr) || (m_done && !stall_me)) begin
        op_wb = wb_wdata;
        fin = 1;
      end
      if (m_granted && !m_done) w++;
      if (m_done) s++;
      op_cycles++;
    end
    if (!fin) post("op_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int kind;
    logic [2:0] f3v;
    rst = 1'b1;
    mem_memrd = 0; mem_memwr = 0; mem_mem2reg = 1; mem_func3 = 0; stall_me = 0;
    mem_wdata = 32'h0; mem_wreg_data = 32'h0;
    dm_if.dm_gnt = 0; dm_if.dm_rvalid = 0; dm_if.dm_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #3;
    post("reset_dm_req", {31'b0, dm_if.dm_req}, 32'd0);
    post("reset_stallreq", {31'b0, stallreq_mem}, 32'd0);
    post("reset_misalign", {31'b0, misalign}, 32'd0);
    post("reset_ld_q", wb_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1;

    do_op(0, 1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 0, 32'h0, 0);
    post("sw_be", {28'b0, op_be}, 32'hF);
    post("sw_addr", op_addr, 32'h100);
    post("sw_wdata", op_wd, 32'hDEADBEEF);
    post("sw_stalls", op_stalls, 32'd1);
    post("sw_cycles", op_cycles, 32'd2);

    do_op(0, 1, 0, 3'b000, 32'h103, 32'h000000A5, 0, 1, 0, 32'h0, 0);
    post("sb_be", {28'b0, op_be}, 32'h8);
    post("sb_wdata", op_wd, 32'hA5A5A5A5);

    do_op(0, 1, 0, 3'b001, 32'h102, 32'h00001234, 0, 1, 0, 32'h0, 0);
    post("sh_be", {28'b0, op_be}, 32'hC);
    post("sh_wdata", op_wd, 32'h12341234);

    do_op(1, 0, 1, 3'b000, 32'h201, 32'h0, 0, 3, 0, 32'h000080FF, 1);
    post("lb_wb", op_wb, 32'hFFFFFF80);
    post("lb_stalls", op_stalls, 32'd4);
    do_op(1, 0, 1, 3'b100, 32'h201, 32'h0, 0, 3, 0, 32'h000080FF, 1);
    post("lbu_wb", op_wb, 32'h00000080);
    post("lbu_stalls", op_stalls, 32'd4);

    do_op(1, 0, 1, 3'b010, 32'h208, 32'h0, 4, 1, 0, 32'h11223344, 1);
    post("lw_wait_reqs", op_reqs, 32'd5);
    post("lw_wait_hs", op_hs, 32'd1);
    post("lw_wait_stalls", op_stalls, 32'd6);
    post("lw_wait_wb", op_wb, 32'h11223344);

    do_op(1, 0, 1, 3'b010, 32'h300, 32'h0, 0, 1, 3, 32'hCAFEF00D, 1);
    post("stallme_reqs", op_reqs, 32'd1);
    post("stallme_cycles", op_cycles, 32'd6);
    post("stallme_wb", op_wb, 32'hCAFEF00D);

    // reset while waiting for read data, then a stray rvalid
    @(negedge clk);
    mem_memrd = 1; mem_memwr = 0; mem_mem2reg = 1; mem_func3 = 3'b010; mem_wdata = 32'h400;
    stall_me = 0; dm_if.dm_gnt = 1; dm_if.dm_rvalid = 0; dm_if.dm_rdata = $urandom();
    @(negedge clk);
    dm_if.dm_gnt = 0;
    #3;
    post("rst_wait_stall", {31'b0, stallreq_mem}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_memrd = 0; dm_if.dm_rvalid = 1; dm_if.dm_rdata = 32'h12345678;
    #3;
    post("rst_ld_q", wb_wdata, 32'd0);
    post("rst_stall", {31'b0, stallreq_mem}, 32'd0);
    @(negedge clk);
    dm_if.dm_rvalid = 0;
    #3;
    post("rst_rvalid_ign", wb_wdata, 32'd0);

    do_op(1, 0, 1, 3'b010, 32'h102, 32'h0, 0, 1, 0, 32'h55667788, 1);
`ifdef LSU_MISALIGN_CHECK_EN
    post("mis_flag", {31'b0, op_mis}, 32'd1);
    post("mis_reqs", op_reqs, 32'd0);
    post("mis_stalls", op_stalls, 32'd1);
    post("mis_wb", op_wb, 32'd0);
`else
    post("mis_flag", {31'b0, op_mis}, 32'd0);
    post("mis_addr", op_addr, 32'h100);
    post("mis_wb", op_wb, 32'h55667788);
`endif

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(9);
      f3v  = 3'($urandom_range(7));
      if (kind <= 3)
        do_op(1, 0, 1, f3v, $urandom(), $urandom(), $urandom_range(3), $urandom_range(3) + 1, $urandom_range(2), 32'h0, 0);
      else if (kind <= 6)
        do_op(0, 1, 0, f3v, $urandom(), $urandom(), $urandom_range(3), 1, $urandom_range(2), 32'h0, 0);
      else if (kind <= 8)
        do_op(0, 0, 1'($urandom_range(1)), f3v, $urandom(), $urandom(), 0, 1, 0, 32'h0, 0);
      else
        do_op(1, 1, 0, f3v, $urandom(), $urandom(), $urandom_range(3), 1, $urandom_range(2), 32'h0, 0);
    end

    @(negedge clk);
    mem_memrd = 0; mem_memwr = 0; dm_if.dm_gnt = 0; dm_if.dm_rvalid = 0; stall_me = 0;
    repeat (3) @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
